// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer.
// Entry layout, entry type encodings and the operand lookup helper.
package reorder_buffer_pkg;

    localparam int ROB_POS_W = 4;
    localparam int ROB_SIZE  = 1 << ROB_POS_W;

    typedef logic [ROB_POS_W-1:0] rob_pos_t;

    typedef enum logic [1:0] {
        ROB_REG   = 2'd0,
        ROB_STORE = 2'd1,
        ROB_BR    = 2'd2,
        ROB_JALR  = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] pc;
        logic        pred_jump;
        logic        real_jump;
        logic [31:0] target;
        logic [31:0] pred_tgt;
    } rob_entry_t;

    // Operand lookup: result buses bypass the stored entry.
    function automatic logic [32:0] rob_lookup(
        input rob_entry_t  e,
        input rob_pos_t    p,
        input logic        av,
        input rob_pos_t    ap,
        input logic [31:0] aval,
        input logic        lv,
        input rob_pos_t    lp,
        input logic [31:0] lval
    );
        logic [32:0] r;
        r = {e.busy && e.ready, e.val};
        if (lv && lp == p) r = {1'b1, lval};
        if (av && ap == p) r = {1'b1, aval};
        return r;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, writeback, query and retire signals of the reorder buffer.
// master = issue/execute side, slave = reorder buffer.
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
;
    logic        issue;
    rob_type_e   issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        issue_pred_jump;
    logic        issue_ready;
    logic [31:0] issue_val;
    rob_pos_t    next_rob_pos;
    logic        rob_full;

    logic        alu_valid;
    rob_pos_t    alu_rob_pos;
    logic [31:0] alu_val;
    logic        alu_jump;
    logic [31:0] alu_target;
    logic        lsb_valid;
    rob_pos_t    lsb_rob_pos;
    logic [31:0] lsb_val;

    rob_pos_t    q1_pos;
    rob_pos_t    q2_pos;
    logic        q1_ready;
    logic        q2_ready;
    logic [31:0] q1_val;
    logic [31:0] q2_val;

    logic        commit;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    rob_pos_t    commit_rob_pos;
    logic        commit_store;
    logic        br_commit;
    logic [31:0] br_pc;
    logic        br_taken;
    logic        rollback;
    logic [31:0] rollback_pc;

    modport master (
        output issue, issue_type, issue_rd, issue_pc,
        output issue_pred_jump, issue_ready, issue_val,
        input  next_rob_pos, rob_full,
        output alu_valid, alu_rob_pos, alu_val,
        output alu_jump, alu_target,
        output lsb_valid, lsb_rob_pos, lsb_val,
        output q1_pos, q2_pos,
        input  q1_ready, q2_ready, q1_val, q2_val,
        input  commit, commit_rd, commit_val, commit_rob_pos,
        input  commit_store, br_commit, br_pc, br_taken,
        input  rollback, rollback_pc
    );

    modport slave (
        input  issue, issue_type, issue_rd, issue_pc,
        input  issue_pred_jump, issue_ready, issue_val,
        output next_rob_pos, rob_full,
        input  alu_valid, alu_rob_pos, alu_val,
        input  alu_jump, alu_target,
        input  lsb_valid, lsb_rob_pos, lsb_val,
        input  q1_pos, q2_pos,
        output q1_ready, q2_ready, q1_val, q2_val,
        output commit, commit_rd, commit_val, commit_rob_pos,
        output commit_store, br_commit, br_pc, br_taken,
        output rollback, rollback_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer with in-order retire.
// Mispredicted branches raise a one-cycle rollback that flushes all entries.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    reorder_buffer_if.slave rob
);

    localparam logic [ROB_POS_W:0] FULL_CNT = (ROB_POS_W+1)'(ROB_SIZE);

    rob_entry_t ent_q [ROB_SIZE];
    rob_entry_t ent_d [ROB_SIZE];

    rob_pos_t           head_q, head_d;
    rob_pos_t           tail_q, tail_d;
    logic [ROB_POS_W:0] count_q, count_d;

    logic        commit_q, commit_d;
    logic [4:0]  commit_rd_q, commit_rd_d;
    logic [31:0] commit_val_q, commit_val_d;
    rob_pos_t    commit_pos_q, commit_pos_d;
    logic        commit_store_q, commit_store_d;
    logic        br_commit_q, br_commit_d;
    logic [31:0] br_pc_q, br_pc_d;
    logic        br_taken_q, br_taken_d;
    logic        rollback_q, rollback_d;
    logic [31:0] rollback_pc_q, rollback_pc_d;

    rob_entry_t  head_ent;
    logic        full;
    logic        do_issue;
    logic        do_commit;
    logic        is_br;
    logic        mispredict;
    logic [32:0] q1_res;
    logic [32:0] q2_res;

    // Head entry decode and issue/retire qualification
    always_comb begin
        head_ent   = ent_q[head_q];
        full       = (count_q == FULL_CNT);
        do_issue   = rob.issue && !full && !rollback_q;
        do_commit  = head_ent.busy && head_ent.ready && !rollback_q;
        is_br      = (head_ent.typ == ROB_BR) || (head_ent.typ == ROB_JALR);
        mispredict = is_br && ((head_ent.real_jump != head_ent.pred_jump)
                  || (head_ent.typ == ROB_JALR && head_ent.real_jump
                      && head_ent.target != head_ent.pred_tgt));
    end

    // Entry array and pointer update: flush, issue, writeback, retire
    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rollback_q) begin
            for (int i = 0; i < ROB_SIZE; i++) ent_d[i].busy = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_issue) begin
                ent_d[tail_q] = '{
                    busy:      1'b1,
                    ready:     rob.issue_ready,
                    typ:       rob.issue_type,
                    rd:        rob.issue_rd,
                    val:       rob.issue_val,
                    pc:        rob.issue_pc,
                    pred_jump: rob.issue_pred_jump,
                    real_jump: 1'b0,
                    target:    '0,
                    pred_tgt:  rob.issue_val
                };
                tail_d = tail_q + 1'b1;
            end
            if (rob.alu_valid) begin
                ent_d[rob.alu_rob_pos].ready     = 1'b1;
                ent_d[rob.alu_rob_pos].val       = rob.alu_val;
                ent_d[rob.alu_rob_pos].real_jump = rob.alu_jump;
                ent_d[rob.alu_rob_pos].target    = rob.alu_target;
            end
            if (rob.lsb_valid) begin
                ent_d[rob.lsb_rob_pos].ready = 1'b1;
                ent_d[rob.lsb_rob_pos].val   = rob.lsb_val;
            end
            if (do_commit) begin
                ent_d[head_q].busy = 1'b0;
                head_d = head_q + 1'b1;
            end
            count_d = count_q + (ROB_POS_W+1)'(do_issue)
                              - (ROB_POS_W+1)'(do_commit);
        end
    end

    // Retire outputs: pulses default low, data holds between retires
    always_comb begin
        commit_d       = 1'b0;
        commit_store_d = 1'b0;
        br_commit_d    = 1'b0;
        rollback_d     = 1'b0;
        commit_rd_d    = commit_rd_q;
        commit_val_d   = commit_val_q;
        commit_pos_d   = commit_pos_q;
        br_pc_d        = br_pc_q;
        br_taken_d     = br_taken_q;
        rollback_pc_d  = rollback_pc_q;
        if (do_commit) begin
            commit_pos_d = head_q;
            unique case (head_ent.typ)
                ROB_REG: commit_d = 1'b1;
                ROB_STORE: commit_store_d = 1'b1;
                ROB_BR: br_commit_d = 1'b1;
                ROB_JALR: begin
                    commit_d    = 1'b1;
                    br_commit_d = 1'b1;
                end
            endcase
            if (commit_d) begin
                commit_rd_d  = head_ent.rd;
                commit_val_d = head_ent.val;
            end
            if (is_br) begin
                br_pc_d       = head_ent.pc;
                br_taken_d    = head_ent.real_jump;
                rollback_d    = mispredict;
                rollback_pc_d = head_ent.real_jump ? head_ent.target
                                                   : head_ent.pc + 32'd4;
            end
        end
    end

    // Operand queries with same-cycle result bus bypass
    always_comb begin
        q1_res = rob_lookup(ent_q[rob.q1_pos], rob.q1_pos,
                            rob.alu_valid, rob.alu_rob_pos, rob.alu_val,
                            rob.lsb_valid, rob.lsb_rob_pos, rob.lsb_val);
        q2_res = rob_lookup(ent_q[rob.q2_pos], rob.q2_pos,
                            rob.alu_valid, rob.alu_rob_pos, rob.alu_val,
                            rob.lsb_valid, rob.lsb_rob_pos, rob.lsb_val);
        if (rst) begin
            q1_res = '0;
            q2_res = '0;
        end
    end

    // State registers; rdy low freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) ent_q[i] <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_q       <= 1'b0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_pos_q   <= '0;
            commit_store_q <= 1'b0;
            br_commit_q    <= 1'b0;
            br_pc_q        <= '0;
            br_taken_q     <= 1'b0;
            rollback_q     <= 1'b0;
            rollback_pc_q  <= '0;
        end else if (rdy) begin
            ent_q          <= ent_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_q       <= commit_d;
            commit_rd_q    <= commit_rd_d;
            commit_val_q   <= commit_val_d;
            commit_pos_q   <= commit_pos_d;
            commit_store_q <= commit_store_d;
            br_commit_q    <= br_commit_d;
            br_pc_q        <= br_pc_d;
            br_taken_q     <= br_taken_d;
            rollback_q     <= rollback_d;
            rollback_pc_q  <= rollback_pc_d;
        end
    end

    assign rob.next_rob_pos   = tail_q;
    assign rob.rob_full       = full;
    assign rob.q1_ready       = q1_res[32];
    assign rob.q1_val         = q1_res[31:0];
    assign rob.q2_ready       = q2_res[32];
    assign rob.q2_val         = q2_res[31:0];
    assign rob.commit         = commit_q;
    assign rob.commit_rd      = commit_rd_q;
    assign rob.commit_val     = commit_val_q;
    assign rob.commit_rob_pos = commit_pos_q;
    assign rob.commit_store   = commit_store_q;
    assign rob.br_commit      = br_commit_q;
    assign rob.br_pc          = br_pc_q;
    assign rob.br_taken       = br_taken_q;
    assign rob.rollback       = rollback_q;
    assign rob.rollback_pc    = rollback_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer.
// Expected retires are queued at issue and checked as they come out.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    typedef struct {
        logic        c;
        logic        s;
        logic        b;
        logic        rb;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  pos;
        logic [31:0] rb_pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] tb_tail = '0;
    exp_t sb[$];

    reorder_buffer_if rif ();

    reorder_buffer dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .rob(rif)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Retire monitor: every pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && rdy &&
            (rif.commit || rif.commit_store || rif.br_commit)) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL retire_unexpected pos=%0d rd=%0d val=%h",
                         rif.commit_rob_pos, rif.commit_rd, rif.commit_val);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({rif.commit, rif.commit_store, rif.br_commit,
                     rif.rollback} !== {e.c, e.s, e.b, e.rb}
                    || rif.commit_rob_pos !== e.pos
                    || (e.c && (rif.commit_rd !== e.rd
                                || rif.commit_val !== e.val))
                    || (e.rb && rif.rollback_pc !== e.rb_pc)) begin
                    fails++;
                    $display("FAIL retire got c%b s%b b%b rb%b pos=%0d rd=%0d val=%h rbpc=%h want c%b s%b b%b rb%b pos=%0d rd=%0d val=%h rbpc=%h",
                        rif.commit, rif.commit_store, rif.br_commit,
                        rif.rollback, rif.commit_rob_pos, rif.commit_rd,
                        rif.commit_val, rif.rollback_pc, e.c, e.s, e.b,
                        e.rb, e.pos, e.rd, e.val, e.rb_pc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.issue = 0; rif.issue_type = ROB_REG; rif.issue_rd = 0;
        rif.issue_pc = 0; rif.issue_pred_jump = 0;
        rif.issue_ready = 0; rif.issue_val = 0;
        rif.alu_valid = 0; rif.alu_rob_pos = 0; rif.alu_val = 0;
        rif.alu_jump = 0; rif.alu_target = 0;
        rif.lsb_valid = 0; rif.lsb_rob_pos = 0; rif.lsb_val = 0;
        rif.q1_pos = 0; rif.q2_pos = 0;
    endtask

    task automatic set_issue(input rob_type_e t, input logic [4:0] rd,
                             input logic [31:0] pc, input logic pj,
                             input logic rd_y, input logic [31:0] v);
        rif.issue = 1; rif.issue_type = t; rif.issue_rd = rd;
        rif.issue_pc = pc; rif.issue_pred_jump = pj;
        rif.issue_ready = rd_y; rif.issue_val = v;
    endtask

    task automatic do_issue(input rob_type_e t, input logic [4:0] rd,
                            input logic [31:0] pc, input logic pj,
                            input logic rd_y, input logic [31:0] v);
        set_issue(t, rd, pc, pj, rd_y, v);
        step();
        rif.issue = 0;
    endtask

    task automatic wb_alu(input logic [3:0] p, input logic [31:0] v,
                          input logic j, input logic [31:0] tg);
        rif.alu_valid = 1; rif.alu_rob_pos = p; rif.alu_val = v;
        rif.alu_jump = j; rif.alu_target = tg;
        step();
        rif.alu_valid = 0;
    endtask

    task automatic wb_lsb(input logic [3:0] p, input logic [31:0] v);
        rif.lsb_valid = 1; rif.lsb_rob_pos = p; rif.lsb_val = v;
        step();
        rif.lsb_valid = 0;
    endtask

    task automatic push(input logic c, input logic s, input logic b,
                        input logic rb, input logic [4:0] rd,
                        input logic [31:0] v, input logic [3:0] p,
                        input logic [31:0] rbpc);
        exp_t e;
        e.c = c; e.s = s; e.b = b; e.rb = rb;
        e.rd = rd; e.val = v; e.pos = p; e.rb_pc = rbpc;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s drain left=%0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        repeat (3) step();
        tests++;
        if ({rif.commit, rif.commit_store, rif.br_commit, rif.rollback,
             rif.rob_full} !== 5'b0 || rif.next_rob_pos !== 4'd0
            || rif.commit_val !== 32'd0 || rif.rollback_pc !== 32'd0) begin
            fails++;
            $display("FAIL reset_state pulses=%b full=%b pos=%0d want 0",
                     {rif.commit, rif.commit_store, rif.br_commit,
                      rif.rollback}, rif.rob_full, rif.next_rob_pos);
        end
        rst = 0;
        tb_tail = 0;
        step();
    endtask

    task automatic test_basic();
        tests++;
        if (rif.next_rob_pos !== tb_tail) begin
            fails++;
            $display("FAIL basic_tag got %0d want %0d",
                     rif.next_rob_pos, tb_tail);
        end
        push(1, 0, 0, 0, 5, 32'h1234, tb_tail, 0);
        do_issue(ROB_REG, 5, 32'h0, 0, 1, 32'h1234);
        tb_tail++;
        step();
        tests++;
        if (rif.commit !== 1'b1 || rif.commit_rd !== 5'd5) begin
            fails++;
            $display("FAIL basic_latency commit=%b rd=%0d want 1 5",
                     rif.commit, rif.commit_rd);
        end
        drain("basic");
    endtask

    task automatic test_full();
        logic [3:0] base;
        base = tb_tail;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (rif.next_rob_pos !== tb_tail) begin
                fails++;
                $display("FAIL full_tag%0d got %0d want %0d",
                         i, rif.next_rob_pos, tb_tail);
            end
            push(1, 0, 0, 0, 5'(i + 1), 32'h100 + i, tb_tail, 0);
            do_issue(ROB_REG, 5'(i + 1), 32'h0, 0, 0, 32'h0);
            tb_tail++;
        end
        tests++;
        if (rif.rob_full !== 1'b1) begin
            fails++;
            $display("FAIL full_flag got %b want 1", rif.rob_full);
        end
        do_issue(ROB_REG, 31, 32'h0, 0, 1, 32'hDEAD);
        tests++;
        if (rif.rob_full !== 1'b1 || rif.next_rob_pos !== tb_tail) begin
            fails++;
            $display("FAIL full_17th full=%b pos=%0d want 1 %0d",
                     rif.rob_full, rif.next_rob_pos, tb_tail);
        end
        wb_alu(base + 4'd1, 32'h101, 0, 0);
        repeat (3) step();
        tests++;
        if (rif.commit !== 1'b0) begin
            fails++;
            $display("FAIL full_order commit=%b want 0", rif.commit);
        end
        wb_alu(base, 32'h100, 0, 0);
        step();
        tests++;
        if (rif.commit !== 1'b1 || rif.commit_rob_pos !== base) begin
            fails++;
            $display("FAIL full_pos0 commit=%b pos=%0d want 1 %0d",
                     rif.commit, rif.commit_rob_pos, base);
        end
        step();
        tests++;
        if (rif.commit !== 1'b1 || rif.commit_rob_pos !== base + 4'd1) begin
            fails++;
            $display("FAIL full_pos1 commit=%b pos=%0d want 1 %0d",
                     rif.commit, rif.commit_rob_pos, base + 4'd1);
        end
        for (int i = 2; i < 16; i++) wb_lsb(base + 4'(i), 32'h100 + i);
        drain("full");
    endtask

    task automatic test_branch_taken();
        logic [3:0] p;
        p = tb_tail;
        push(0, 0, 1, 1, 0, 0, p, 32'h200);
        do_issue(ROB_BR, 0, 32'h100, 0, 0, 32'h0);
        do_issue(ROB_REG, 3, 32'h104, 0, 1, 32'h33);
        do_issue(ROB_REG, 4, 32'h108, 0, 1, 32'h44);
        wb_alu(p, 32'h0, 1, 32'h200);
        step();
        tests++;
        if (rif.rollback !== 1'b1 || rif.br_commit !== 1'b1
            || rif.rollback_pc !== 32'h200 || rif.br_taken !== 1'b1
            || rif.br_pc !== 32'h100) begin
            fails++;
            $display("FAIL br_taken rb=%b br=%b pc=%h want 1 1 200",
                     rif.rollback, rif.br_commit, rif.rollback_pc);
        end
        set_issue(ROB_REG, 9, 32'h0, 0, 1, 32'hBAD);
        step();
        rif.issue = 0;
        tb_tail = 0;
        tests++;
        if (rif.rob_full !== 1'b0 || rif.next_rob_pos !== 4'd0
            || rif.rollback !== 1'b0) begin
            fails++;
            $display("FAIL br_flush full=%b pos=%0d rb=%b want 0 0 0",
                     rif.rob_full, rif.next_rob_pos, rif.rollback);
        end
        push(1, 0, 0, 0, 6, 32'hAB, 0, 0);
        do_issue(ROB_REG, 6, 32'h200, 0, 1, 32'hAB);
        tb_tail++;
        drain("br_taken");
    endtask

    task automatic test_branch_not_taken();
        logic [3:0] p;
        p = tb_tail;
        push(0, 0, 1, 1, 0, 0, p, 32'h44);
        do_issue(ROB_BR, 0, 32'h40, 1, 0, 32'h0);
        wb_alu(p, 32'h0, 0, 32'h0);
        drain("br_not_taken");
        tb_tail = 0;
        tests++;
        if (rif.next_rob_pos !== 4'd0) begin
            fails++;
            $display("FAIL br_nt_flush pos=%0d want 0", rif.next_rob_pos);
        end
    endtask

    task automatic test_bypass();
        logic [3:0] b;
        b = tb_tail;
        push(1, 0, 0, 0, 10, 32'h10, b, 0);
        push(1, 0, 0, 0, 11, 32'h11, b + 4'd1, 0);
        push(1, 0, 0, 0, 12, 32'd7, b + 4'd2, 0);
        push(1, 0, 0, 0, 13, 32'd9, b + 4'd3, 0);
        for (int i = 0; i < 4; i++)
            do_issue(ROB_REG, 5'(10 + i), 32'h0, 0, 0, 32'h0);
        tb_tail += 4'd4;
        rif.q1_pos = b;
        #1;
        tests++;
        if (rif.q1_ready !== 1'b0) begin
            fails++;
            $display("FAIL byp_notready got %b want 0", rif.q1_ready);
        end
        rif.alu_valid = 1; rif.alu_rob_pos = b + 4'd2; rif.alu_val = 7;
        rif.lsb_valid = 1; rif.lsb_rob_pos = b + 4'd3; rif.lsb_val = 9;
        rif.q1_pos = b + 4'd2;
        rif.q2_pos = b + 4'd3;
        #1;
        tests++;
        if (rif.q1_ready !== 1'b1 || rif.q1_val !== 32'd7
            || rif.q2_ready !== 1'b1 || rif.q2_val !== 32'd9) begin
            fails++;
            $display("FAIL byp_same q1=%b/%0d q2=%b/%0d want 1/7 1/9",
                     rif.q1_ready, rif.q1_val, rif.q2_ready, rif.q2_val);
        end
        step();
        rif.alu_valid = 0;
        rif.lsb_valid = 0;
        tests++;
        if (rif.q1_ready !== 1'b1 || rif.q1_val !== 32'd7) begin
            fails++;
            $display("FAIL byp_stored q1=%b/%0d want 1/7",
                     rif.q1_ready, rif.q1_val);
        end
        rif.alu_valid = 1; rif.alu_rob_pos = b; rif.alu_val = 32'h10;
        rif.lsb_valid = 1; rif.lsb_rob_pos = b + 4'd1; rif.lsb_val = 32'h11;
        step();
        rif.alu_valid = 0;
        rif.lsb_valid = 0;
        drain("bypass");
    endtask

    task automatic test_store();
        logic [3:0] p;
        p = tb_tail;
        push(0, 1, 0, 0, 0, 0, p, 0);
        do_issue(ROB_STORE, 0, 32'h60, 0, 0, 32'h0);
        tb_tail++;
        wb_lsb(p, 32'h0);
        drain("store");
    endtask

    task automatic test_jalr();
        logic [3:0] p;
        p = tb_tail;
        push(1, 0, 1, 0, 1, 32'h84, p, 0);
        do_issue(ROB_JALR, 1, 32'h80, 1, 0, 32'h300);
        tb_tail++;
        wb_alu(p, 32'h84, 1, 32'h300);
        drain("jalr_hit");
        p = tb_tail;
        push(1, 0, 1, 1, 2, 32'h94, p, 32'h304);
        do_issue(ROB_JALR, 2, 32'h90, 1, 0, 32'h300);
        wb_alu(p, 32'h94, 1, 32'h304);
        drain("jalr_miss");
        tb_tail = 0;
    endtask

    task automatic test_rdy();
        push(1, 0, 0, 0, 7, 32'h55, tb_tail, 0);
        do_issue(ROB_REG, 7, 32'h0, 0, 1, 32'h55);
        tb_tail++;
        rdy = 0;
        set_issue(ROB_REG, 8, 32'h0, 0, 1, 32'h66);
        repeat (4) step();
        rif.issue = 0;
        tests++;
        if (rif.commit !== 1'b0 || rif.next_rob_pos !== tb_tail) begin
            fails++;
            $display("FAIL rdy_freeze commit=%b pos=%0d want 0 %0d",
                     rif.commit, rif.next_rob_pos, tb_tail);
        end
        rdy = 1;
        drain("rdy");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            tests++;
            if (rif.next_rob_pos !== tb_tail) begin
                fails++;
                $display("FAIL wrap_tag%0d got %0d want %0d",
                         i, rif.next_rob_pos, tb_tail);
            end
            push(1, 0, 0, 0, 5'(i), 32'hA000 + i, tb_tail, 0);
            set_issue(ROB_REG, 5'(i), 32'h0, 0, 1, 32'hA000 + i);
            step();
            tb_tail++;
        end
        rif.issue = 0;
        drain("wrap");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            do_issue(ROB_REG, 5'(20 + i), 32'h0, 0, 0, 32'h0);
        rif.alu_valid = 1; rif.alu_rob_pos = 0; rif.alu_val = 32'hFF;
        rif.q1_pos = 0;
        rst = 1;
        #1;
        tests++;
        if ({rif.commit, rif.rollback, rif.rob_full, rif.q1_ready} !== 4'b0
            || rif.commit_val !== 32'd0 || rif.commit_rd !== 5'd0
            || rif.next_rob_pos !== 4'd0 || rif.q1_val !== 32'd0) begin
            fails++;
            $display("FAIL rst_mid c=%b val=%h pos=%0d q1=%b want 0",
                     rif.commit, rif.commit_val, rif.next_rob_pos,
                     rif.q1_ready);
        end
        rif.alu_valid = 0;
        step();
        rst = 0;
        tb_tail = 0;
        for (int i = 0; i < 3; i++) wb_alu(4'(i), 32'h1, 0, 0);
        repeat (4) step();
        push(1, 0, 0, 0, 15, 32'h77, 0, 0);
        do_issue(ROB_REG, 15, 32'h0, 0, 1, 32'h77);
        drain("rst_mid");
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_full();
        test_branch_taken();
        test_branch_not_taken();
        test_bypass();
        test_store();
        test_jalr();
        test_rdy();
        test_wrap();
        test_reset_mid();
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
